// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch control: button sync, run/pause/lap/alarm FSM, 1 Hz tick and display hold
module stopwatch_ctrl #(
  parameter int TICK_DIV = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clear,
  input  logic [5:0] sec_in,
  input  logic [5:0] min_in,
  input  logic       alarm_en,
  input  logic [5:0] alarm_sec,
  input  logic [5:0] alarm_min,
  output logic       sec_en,
  output logic       min_en,
  output logic       cnt_clr,
  output logic [5:0] disp_sec,
  output logic [5:0] disp_min,
  output logic [2:0] state,
  output logic       alarm,
  output logic       ovf
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    PAUSE = 3'd2,
    LAP   = 3'd3,
    ALARM = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    btn_s1, btn_s2, btn_d;
  logic [2:0]    press;
  logic          clr_p, start_p, lap_p, any_p;
  logic [PW-1:0] presc;
  logic          running, tick, match, do_clr, lap_cap;
  logic [5:0]    lap_sec, lap_min;

  // Button vector order is {clear, start, lap}
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      btn_d  <= '0;
    end else begin
      btn_s1 <= {btn_clear, btn_start, btn_lap};
      btn_s2 <= btn_s1;
      btn_d  <= btn_s2;
    end
  end

  assign press   = btn_s2 & ~btn_d;
  assign clr_p   = press[2];
  assign start_p = press[1] & ~press[2];
  assign lap_p   = press[0] & ~press[1] & ~press[2];
  assign any_p   = |press;

  assign running = (state_q == RUN) || (state_q == LAP);
  assign tick    = running && (presc == PRESC_LAST);
  assign match   = alarm_en && running && (sec_in == alarm_sec) && (min_in == alarm_min)
                   && !((alarm_sec == 6'd0) && (alarm_min == 6'd0));
  // A match suppresses the tick so the chain stops exactly on the target
  assign sec_en  = tick && !match;
  assign min_en  = sec_en && (sec_in == 6'd59);

  always_comb begin
    state_d = state_q;
    do_clr  = 1'b0;
    lap_cap = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_p)        do_clr  = 1'b1;
        else if (start_p) state_d = RUN;
      end
      RUN: begin
        if (start_p)      state_d = PAUSE;
        else if (lap_p) begin
          state_d = LAP;
          lap_cap = 1'b1;
        end
        else if (match)   state_d = ALARM;
      end
      LAP: begin
        if (start_p)      state_d = PAUSE;
        else if (lap_p)   state_d = RUN;
        else if (match)   state_d = ALARM;
      end
      PAUSE: begin
        if (clr_p) begin
          state_d = IDLE;
          do_clr  = 1'b1;
        end
        else if (start_p) state_d = RUN;
      end
      ALARM: begin
        if (any_p) begin
          state_d = IDLE;
          do_clr  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_clr  <= 1'b0;
      presc    <= '0;
      ovf      <= 1'b0;
      lap_sec  <= '0;
      lap_min  <= '0;
      disp_sec <= '0;
      disp_min <= '0;
    end else begin
      state_q <= state_d;
      cnt_clr <= do_clr;
      if (do_clr)
        presc <= '0;
      else if (running)
        presc <= tick ? '0 : presc + PW'(1);
      if (do_clr)
        ovf <= 1'b0;
      else if (sec_en && (sec_in == 6'd59) && (min_in == 6'd59))
        ovf <= 1'b1;
      if (lap_cap) begin
        lap_sec <= sec_in;
        lap_min <= min_in;
      end
      // Frozen lap value shows while in LAP; live counts otherwise
      if (state_q == LAP) begin
        disp_sec <= lap_sec;
        disp_min <= lap_min;
      end else begin
        disp_sec <= sec_in;
        disp_min <= min_in;
      end
    end
  end

  assign state = state_q;
  assign alarm = (state_q == ALARM);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl with TICK_DIV=4
module tb_stopwatch_ctrl;

  logic       clk, reset, btn_start, btn_lap, btn_clear, alarm_en;
  logic [5:0] sec_in, min_in, alarm_sec, alarm_min;
  logic       sec_en, min_en, cnt_clr, alarm, ovf;
  logic [5:0] disp_sec, disp_min;
  logic [2:0] state;

  logic       ld, env_count, sb_on;
  logic [5:0] ld_sec, ld_min;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  typedef struct {
    int   cyc;
    logic men;
  } exp_t;
  exp_t sb[$];

  stopwatch_ctrl #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset),
    .btn_start(btn_start), .btn_lap(btn_lap), .btn_clear(btn_clear),
    .sec_in(sec_in), .min_in(min_in),
    .alarm_en(alarm_en), .alarm_sec(alarm_sec), .alarm_min(alarm_min),
    .sec_en(sec_en), .min_en(min_en), .cnt_clr(cnt_clr),
    .disp_sec(disp_sec), .disp_min(disp_min),
    .state(state), .alarm(alarm), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Model of the two mod-60 counters fed by the DUT enables
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      sec_in <= 6'd0;
      min_in <= 6'd0;
    end else if (ld) begin
      sec_in <= ld_sec;
      min_in <= ld_min;
    end else if (cnt_clr) begin
      sec_in <= 6'd0;
      min_in <= 6'd0;
    end else if (env_count) begin
      if (sec_en) sec_in <= (sec_in == 6'd59) ? 6'd0 : sec_in + 6'd1;
      if (min_en) min_in <= (min_in == 6'd59) ? 6'd0 : min_in + 6'd1;
    end
  end

  // Scoreboard consumer: every sec_en pulse must match the next predicted cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_on && !reset) begin
        if (sec_en) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sec_en_unexpected got pulse at cycle %0d exp none", cyc);
          end else begin
            e = sb.pop_front();
            if (e.cyc !== cyc || e.men !== min_en) begin
              errors++;
              $display("FAIL sec_en_pulse got cycle %0d min_en %0b exp cycle %0d min_en %0b",
                       cyc, min_en, e.cyc, e.men);
            end
          end
        end else if (min_en) begin
          checks++;
          errors++;
          $display("FAIL min_en_alone got 1 exp 0 at cycle %0d", cyc);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic s, input logic l, input logic c);
    btn_start = s;
    btn_lap   = l;
    btn_clear = c;
    @(posedge clk);
    #1;
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    btn_clear = 1'b0;
  endtask

  task automatic load(input logic [5:0] s, input logic [5:0] m);
    ld     = 1'b1;
    ld_sec = s;
    ld_min = m;
    @(posedge clk);
    #1;
    ld = 1'b0;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    btn_start = 1'b0;
    btn_lap   = 1'b0;
    btn_clear = 1'b0;
    ld        = 1'b0;
    ld_sec    = 6'd0;
    ld_min    = 6'd0;
    env_count = 1'b0;
    sb_on     = 1'b0;
    alarm_en  = 1'b0;
    alarm_sec = 6'd0;
    alarm_min = 6'd0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++;
    if ({sec_en, min_en, cnt_clr, alarm, ovf} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 00000", {sec_en, min_en, cnt_clr, alarm, ovf});
    end
    checks++;
    if ({disp_sec, disp_min} !== 12'd0) begin
      errors++; $display("FAIL reset_disp got %0d:%0d exp 0:0", disp_min, disp_sec);
    end
    do_reset();
  endtask

  task automatic test_start_count();
    int e;
    do_reset();
    env_count = 1'b1;
    sb_on = 1'b1;
    e = cyc + 3;
    press(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) sb.push_back('{e + 3 + 4 * i, 1'b0});
    wait_cyc(e + 40);
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL start_state got %0d exp 1", state); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL start_pulses_missing got %0d left exp 0", sb.size()); end
    sb_on = 1'b0;
  endtask

  task automatic test_pause_resume();
    int e, c1;
    do_reset();
    env_count = 1'b1;
    sb_on = 1'b1;
    e = cyc + 3;
    press(1'b1, 1'b0, 1'b0);
    sb.push_back('{e + 3, 1'b0});
    wait_cyc(e + 3);
    press(1'b1, 1'b0, 1'b0);
    wait_cyc(e + 14);
    checks++;
    if (state !== 3'd2) begin errors++; $display("FAIL pause_state got %0d exp 2", state); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL pause_pulses_left got %0d exp 0", sb.size()); end
    c1 = cyc;
    press(1'b1, 1'b0, 1'b0);
    sb.push_back('{c1 + 4, 1'b0});
    sb.push_back('{c1 + 8, 1'b0});
    wait_cyc(c1 + 10);
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL resume_state got %0d exp 1", state); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL resume_pulses_missing got %0d left exp 0", sb.size()); end
    sb_on = 1'b0;
  endtask

  task automatic test_lap();
    int c;
    do_reset();
    c = cyc;
    press(1'b1, 1'b0, 1'b0);
    wait_cyc(c + 4);
    load(6'd5, 6'd0);
    c = cyc;
    press(1'b0, 1'b1, 1'b0);
    wait_cyc(c + 4);
    checks++;
    if (state !== 3'd3) begin errors++; $display("FAIL lap_state got %0d exp 3", state); end
    load(6'd8, 6'd0);
    wait_cyc(c + 8);
    checks++;
    if (disp_sec !== 6'd5) begin errors++; $display("FAIL lap_hold got %0d exp 5", disp_sec); end
    c = cyc;
    press(1'b0, 1'b1, 1'b0);
    wait_cyc(c + 4);
    checks++;
    if (state !== 3'd1 || disp_sec !== 6'd8) begin
      errors++; $display("FAIL lap_release got state %0d disp %0d exp state 1 disp 8", state, disp_sec);
    end
    load(6'd9, 6'd0);
    wait_cyc(c + 6);
    checks++;
    if (disp_sec !== 6'd9) begin errors++; $display("FAIL lap_track got %0d exp 9", disp_sec); end
    c = cyc;
    press(1'b0, 1'b1, 1'b0);
    wait_cyc(c + 5);
    c = cyc;
    press(1'b1, 1'b0, 1'b0);
    wait_cyc(c + 3);
    checks++;
    if (state !== 3'd2) begin errors++; $display("FAIL lap_to_pause got %0d exp 2", state); end
  endtask

  task automatic test_overflow();
    int e, c;
    do_reset();
    load(6'd59, 6'd59);
    sb_on = 1'b1;
    e = cyc + 3;
    press(1'b1, 1'b0, 1'b0);
    sb.push_back('{e + 3, 1'b1});
    wait_cyc(e + 2);
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got %0b exp 0", ovf); end
    press(1'b1, 1'b0, 1'b0);
    wait_cyc(e + 6);
    checks++;
    if (state !== 3'd2 || ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_set got state %0d ovf %0b exp state 2 ovf 1", state, ovf);
    end
    c = cyc;
    press(1'b0, 1'b0, 1'b1);
    wait_cyc(c + 2);
    checks++;
    if (cnt_clr !== 1'b0 || ovf !== 1'b1) begin
      errors++; $display("FAIL clr_early got cnt_clr %0b ovf %0b exp 0 1", cnt_clr, ovf);
    end
    wait_cyc(c + 3);
    checks++;
    if (cnt_clr !== 1'b1 || state !== 3'd0 || ovf !== 1'b0) begin
      errors++; $display("FAIL clr_pulse got cnt_clr %0b state %0d ovf %0b exp 1 0 0", cnt_clr, state, ovf);
    end
    wait_cyc(c + 4);
    checks++;
    if (cnt_clr !== 1'b0) begin errors++; $display("FAIL clr_single got %0b exp 0", cnt_clr); end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL ovf_pulse_missing got %0d left exp 0", sb.size()); end
    sb_on = 1'b0;
  endtask

  task automatic test_alarm();
    int e, c;
    do_reset();
    env_count = 1'b1;
    alarm_en  = 1'b1;
    alarm_sec = 6'd3;
    alarm_min = 6'd0;
    sb_on = 1'b1;
    e = cyc + 3;
    press(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) sb.push_back('{e + 3 + 4 * i, 1'b0});
    wait_cyc(e + 12);
    checks++;
    if (state !== 3'd1 || alarm !== 1'b0) begin
      errors++; $display("FAIL alarm_early got state %0d alarm %0b exp 1 0", state, alarm);
    end
    wait_cyc(e + 13);
    checks++;
    if (state !== 3'd4 || alarm !== 1'b1) begin
      errors++; $display("FAIL alarm_enter got state %0d alarm %0b exp 4 1", state, alarm);
    end
    wait_cyc(e + 20);
    checks++;
    if (sec_in !== 6'd3 || sb.size() != 0) begin
      errors++; $display("FAIL alarm_stop got sec %0d left %0d exp 3 0", sec_in, sb.size());
    end
    c = cyc;
    press(1'b0, 1'b1, 1'b0);
    wait_cyc(c + 3);
    checks++;
    if (state !== 3'd0 || cnt_clr !== 1'b1 || alarm !== 1'b0) begin
      errors++; $display("FAIL alarm_exit got state %0d cnt_clr %0b alarm %0b exp 0 1 0", state, cnt_clr, alarm);
    end
    sb_on = 1'b0;
  endtask

  task automatic test_alarm_edge();
    int e, c;
    do_reset();
    alarm_en  = 1'b1;
    alarm_sec = 6'd3;
    alarm_min = 6'd0;
    e = cyc + 3;
    press(1'b1, 1'b0, 1'b0);
    wait_cyc(e + 2);
    load(6'd3, 6'd0);
    checks++;
    if (sec_en !== 1'b0 || state !== 3'd1) begin
      errors++; $display("FAIL alarm_force got sec_en %0b state %0d exp 0 1", sec_en, state);
    end
    wait_cyc(e + 4);
    checks++;
    if (state !== 3'd4) begin errors++; $display("FAIL alarm_force_state got %0d exp 4", state); end
    c = cyc;
    press(1'b1, 1'b0, 1'b0);
    wait_cyc(c + 5);
    alarm_sec = 6'd0;
    load(6'd0, 6'd0);
    c = cyc;
    press(1'b1, 1'b0, 1'b0);
    wait_cyc(c + 12);
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL alarm_zero_target got %0d exp 1", state); end
  endtask

  task automatic test_priority();
    int c;
    do_reset();
    c = cyc;
    press(1'b1, 1'b0, 1'b0);
    wait_cyc(c + 4);
    c = cyc;
    press(1'b1, 1'b0, 1'b0);
    wait_cyc(c + 4);
    c = cyc;
    press(1'b1, 1'b1, 1'b1);
    wait_cyc(c + 3);
    checks++;
    if (state !== 3'd0 || cnt_clr !== 1'b1) begin
      errors++; $display("FAIL prio_all got state %0d cnt_clr %0b exp 0 1", state, cnt_clr);
    end
    wait_cyc(c + 5);
    c = cyc;
    press(1'b1, 1'b0, 1'b0);
    wait_cyc(c + 4);
    c = cyc;
    press(1'b0, 1'b1, 1'b1);
    wait_cyc(c + 4);
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL prio_clear_lap got %0d exp 1", state); end
    c = cyc;
    press(1'b1, 1'b1, 1'b0);
    wait_cyc(c + 3);
    checks++;
    if (state !== 3'd2) begin errors++; $display("FAIL prio_start_lap got %0d exp 2", state); end
  endtask

  task automatic test_held_and_reset();
    int c;
    do_reset();
    c = cyc;
    btn_start = 1'b1;
    wait_cyc(c + 12);
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL held_once got %0d exp 1", state); end
    btn_start = 1'b0;
    wait_cyc(c + 15);
    c = cyc;
    press(1'b1, 1'b0, 1'b0);
    wait_cyc(c + 3);
    checks++;
    if (state !== 3'd2) begin errors++; $display("FAIL held_repress got %0d exp 2", state); end
    c = cyc;
    press(1'b1, 1'b0, 1'b0);
    wait_cyc(c + 5);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0 || cnt_clr !== 1'b0 || sec_en !== 1'b0) begin
      errors++; $display("FAIL async_reset got state %0d cnt_clr %0b sec_en %0b exp 0 0 0", state, cnt_clr, sec_en);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    btn_start = 1'b0;
    btn_lap = 1'b0;
    btn_clear = 1'b0;
    ld = 1'b0;
    ld_sec = 6'd0;
    ld_min = 6'd0;
    env_count = 1'b0;
    sb_on = 1'b0;
    alarm_en = 1'b0;
    alarm_sec = 6'd0;
    alarm_min = 6'd0;
    test_reset();
    test_start_count();
    test_pause_resume();
    test_lap();
    test_overflow();
    test_alarm();
    test_alarm_edge();
    test_priority();
    test_held_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
